bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 97 +++++++++
 tb/tb_bus_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with bounded hold time under contention and per-master lock.
// Define BUS_ARBITER_RR_EN for round-robin arbitration of simultaneous requests from IDLE.
module bus_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic m0_req,
  input  logic m0_lock,
  input  logic m1_req,
  input  logic m1_lock,
  output logic m0_grant,
  output logic m1_grant,
  output logic preempt
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state, state_nx;
  logic [7:0] hold_cnt, hold_nx;
  logic       last_owner, last_nx;
  logic       preempt_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      last_owner <= 1'b1;
      m0_grant   <= 1'b0;
      m1_grant   <= 1'b0;
      preempt    <= 1'b0;
    end else begin
      state      <= state_nx;
      hold_cnt   <= hold_nx;
      last_owner <= last_nx;
      m0_grant   <= (state_nx == GNT0);
      m1_grant   <= (state_nx == GNT1);
      preempt    <= preempt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    hold_nx    = hold_cnt;
    last_nx    = last_owner;
    preempt_nx = 1'b0;
    case (state)
      IDLE: begin
        hold_nx = '0;
        if (m0_req && m1_req) begin
`ifdef BUS_ARBITER_RR_EN
          state_nx = last_owner ? GNT0 : GNT1;
`else
          state_nx = GNT0;
`endif
        end else if (m0_req) begin
          state_nx = GNT0;
        end else if (m1_req) begin
          state_nx = GNT1;
        end
      end
      GNT0: begin
        if (!m0_req) begin
          state_nx = m1_req ? GNT1 : IDLE;
        end else if (m1_req && !m0_lock) begin
          if (hold_cnt == HOLD_LAST) begin
            state_nx   = GNT1;
            preempt_nx = 1'b1;
          end else begin
            hold_nx = hold_cnt + 8'd1;
          end
        end
      end
      GNT1: begin
        if (!m1_req) begin
          state_nx = m0_req ? GNT0 : IDLE;
        end else if (m0_req && !m1_lock) begin
          if (hold_cnt == HOLD_LAST) begin
            state_nx   = GNT0;
            preempt_nx = 1'b1;
          end else begin
            hold_nx = hold_cnt + 8'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    // Any transition into an owned state restarts the hold window and records the owner.
    if (state_nx != state && state_nx != IDLE) begin
      hold_nx = '0;
      last_nx = (state_nx == GNT1);
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random traffic against an ownership model.
module tb_bus_arbiter;
  localparam int unsigned MH = 16;

  logic clk = 1'b0;
  logic reset_n, m0_req, m0_lock, m1_req, m1_lock;
  logic m0_grant, m1_grant, preempt;

  int total = 0;
  int passed = 0;

  // Reference: who owns the bus (-1 none), contended-cycle count, last owner, preempt pulse.
  int who, cnt, last;
  int pre;

  bus_arbiter #(.MAX_HOLD(MH)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_lock(m0_lock), .m1_req(m1_req), .m1_lock(m1_lock),
    .m0_grant(m0_grant), .m1_grant(m1_grant), .preempt(preempt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic void model_reset();
    who = -1; cnt = 0; last = 1; pre = 0;
  endfunction

  function automatic void model_step(input bit r0, input bit l0, input bit r1, input bit l1);
    bit r[2];
    bit l[2];
    int x;
    r[0] = r0; r[1] = r1; l[0] = l0; l[1] = l1;
    pre = 0;
    if (who < 0) begin
      if (r0 && r1) begin
`ifdef BUS_ARBITER_RR_EN
        who = 1 - last;
`else
        who = 0;
`endif
      end else if (r0) who = 0;
      else if (r1) who = 1;
      if (who >= 0) begin cnt = 0; last = who; end
    end else begin
      x = 1 - who;
      if (!r[who]) begin
        who = r[x] ? x : -1;
        cnt = 0;
        if (who >= 0) last = who;
      end else if (r[x] && !l[who]) begin
        if (cnt == int'(MH) - 1) begin
          who = x; cnt = 0; last = x; pre = 1;
        end else cnt = cnt + 1;
      end
    end
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".m0_grant"}, int'(m0_grant), (who == 0) ? 1 : 0);
    check({tag, ".m1_grant"}, int'(m1_grant), (who == 1) ? 1 : 0);
    check({tag, ".preempt"},  int'(preempt),  pre);
  endtask

  // Called at a negedge: drive, clock, update model, sample at the next negedge.
  task automatic step(input bit r0, input bit l0, input bit r1, input bit l1, input string tag);
    m0_req = r0; m0_lock = l0; m1_req = r1; m1_lock = l1;
    @(posedge clk);
    model_step(r0, l0, r1, l1);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    m0_req = 0; m0_lock = 0; m1_req = 0; m1_lock = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("reset");
    reset_n = 1'b1;
  endtask

  initial begin
    int first;
    int npre;
    int g[3];
    int exp_g[3];

    @(negedge clk);
    do_reset();

    // Single master: grant after one edge, release to IDLE.
    step(1, 0, 0, 0, "m0_single");
    check("m0_single.latency", int'(m0_grant), 1);
    repeat (3) step(1, 0, 0, 0, "m0_hold");
    step(0, 0, 0, 0, "m0_release");
    check("m0_release.idle", int'(m0_grant | m1_grant), 0);

    // Forced handover after MAX_HOLD contended edges.
    step(1, 0, 0, 0, "pre_own");
    first = 0; npre = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1, 0, 1, 0, "contend");
      if (m1_grant && first == 0) first = i;
      if (preempt) npre++;
    end
    check("handover_edge", first, int'(MH));
    check("preempt_pulses", npre, 1);
    step(0, 0, 0, 0, "contend_end");
    step(0, 0, 0, 0, "contend_idle");

    // Lock freezes the count; handover after 16 unlocked contended edges total.
    step(1, 0, 0, 0, "lk_own");
    first = 0;
    for (int i = 1; i <= 5; i++) step(1, 0, 1, 0, "lk_pre");
    for (int i = 1; i <= 30; i++) begin
      step(1, 1, 1, 0, "lk_held");
      if (m1_grant) first = -1;
    end
    check("lock_no_handover", first, 0);
    for (int i = 1; i <= 40 && first == 0; i++) begin
      step(1, 0, 1, 0, "lk_post");
      if (m1_grant) first = 5 + i;
    end
    check("lock_handover_edge", first, int'(MH));
    step(0, 0, 0, 0, "lk_end");
    step(0, 0, 0, 0, "lk_idle");

    // Owner release on the same edge the other requests: direct handoff, no preempt.
    step(1, 0, 0, 0, "hand_own");
    step(0, 0, 1, 0, "handoff");
    check("handoff.m1", int'(m1_grant), 1);
    check("handoff.preempt", int'(preempt), 0);

    // Async reset mid-cycle while m1 owns the bus.
    step(0, 0, 1, 0, "pre_rst");
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 0, 0, 0, "post_rst");

    // Three simultaneous contests from IDLE.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 1, 0, "contest");
      g[k] = m1_grant ? 1 : 0;
      step(1, 0, 1, 0, "contest_hold");
      step(0, 0, 0, 0, "contest_rel");
    end
`ifdef BUS_ARBITER_RR_EN
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0;
`else
    exp_g[0] = 0; exp_g[1] = 0; exp_g[2] = 0;
`endif
    for (int k = 0; k < 3; k++) check($sformatf("contest%0d", k), g[k], exp_g[k]);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(9) < 7, $urandom_range(9) < 2,
           $urandom_range(9) < 7, $urandom_range(9) < 2, "random");
      check("random.exclusive", int'(m0_grant & m1_grant), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
